// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the MEM-stage data-memory responder.
//   state_e          : responder FSM encoding (IDLE / BUSY / DONE)
//   WORD_OFFSET_BITS : byte-address bits below the word index
//   be_mask()        : expands 4 byte enables into a 32-bit bit mask
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WORD_OFFSET_BITS = 2;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 single-port storage with byte-write enables and a
// registered read port.
//   clk, rst_n : clock / async active-low reset (read register only)
//   en, we     : access strobe; we=1 write, we=0 read
//   addr       : word index
//   wdata, be  : write data and active-high byte enables
//   rdata      : read register, updated only by a read access
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  // Storage is deliberately not reset.
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= (mem[addr] & ~be_mask(be)) | (wdata & be_mask(be));
  end

  // Read register doubles as the held RDATA output, so it is cleared by
  // reset and only moves on a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata_q <= '0;
    else if (en && !we)  rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MEM-stage control bundle.
// Accepts one access at a time, stalls the pipeline for LATENCY cycles,
// then spends one DONE cycle (STALL low) so the pipeline advances.
//   CLK, RSTn                      : clock, async active-low reset
//   C_MEM_CSN/C_MEM_WEN/C_MEM_REN  : active-low select / write / read
//   ADDR, WDATA, BE                : byte address, write data, byte enables
//   RDATA, RDATA_VALID             : read data (held) and 1-cycle valid
//   STALL                          : access in progress (combinational)
//   ERR                            : 1-cycle pulse after an illegal request
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          C_MEM_CSN,
  input  logic          C_MEM_WEN,
  input  logic          C_MEM_REN,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] WDATA,
  input  logic [3:0]    BE,
  output logic [DW-1:0] RDATA,
  output logic          RDATA_VALID,
  output logic          STALL,
  output logic          ERR
);

  localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q;
  logic [IW-1:0]   idx_q;
  logic [DW-1:0]   wdata_q;
  logic [3:0]      be_q;
  logic            err_q, err_d;
  logic            latch, acc_en;

  // Request decode
  logic          wr_rq, rd_rq, aligned, legal, illegal;
  logic [IW-1:0] idx_in;

  assign wr_rq   = ~C_MEM_CSN & ~C_MEM_WEN &  C_MEM_REN;
  assign rd_rq   = ~C_MEM_CSN &  C_MEM_WEN & ~C_MEM_REN;
  assign aligned = (ADDR[WORD_OFFSET_BITS-1:0] == '0);
  assign legal   = (wr_rq | rd_rq) & aligned;
  assign illegal = ~C_MEM_CSN & ((~C_MEM_WEN & ~C_MEM_REN) | ((wr_rq | rd_rq) & ~aligned));
  assign idx_in  = IW'(ADDR[AW-1:WORD_OFFSET_BITS] % DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    latch   = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          latch = 1'b1;
          cnt_d = CNT_INIT;
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            // Single-cycle latency: the accept edge is also the access edge.
            acc_en  = 1'b1;
            state_d = DONE;
          end
        end else if (illegal) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        // The IDLE accept cycle already counted as one stall cycle, so the
        // access fires on the edge where the counter reaches zero.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc_en  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (latch) begin
        wr_q    <= wr_rq;
        idx_q   <= idx_in;
        wdata_q <= WDATA;
        be_q    <= BE;
      end
    end
  end

  // In IDLE the access (LATENCY==1 only) uses live inputs; afterwards the
  // latched copy, so input wiggles during BUSY are ignored.
  logic            in_idle;
  logic            arr_we;
  logic [IW-1:0]   arr_idx;
  logic [DW-1:0]   arr_wd;
  logic [3:0]      arr_be;

  assign in_idle = (state_q == IDLE);
  assign arr_we  = in_idle ? wr_rq  : wr_q;
  assign arr_idx = in_idle ? idx_in : idx_q;
  assign arr_wd  = in_idle ? WDATA  : wdata_q;
  assign arr_be  = in_idle ? BE     : be_q;

  dmem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
    .clk   (CLK),
    .rst_n (RSTn),
    .en    (acc_en),
    .we    (arr_we),
    .addr  (arr_idx),
    .wdata (arr_wd),
    .be    (arr_be),
    .rdata (RDATA)
  );

  // Gated by RSTn so STALL falls immediately on reset even with a request
  // still on the inputs.
  assign STALL       = RSTn & ((in_idle & legal) | (state_q == BUSY));
  assign RDATA_VALID = (state_q == DONE) & ~wr_q;
  assign ERR         = err_q;

endmodule
